accel_tilt_detect: RTL and testbench
====================================

ACCEL_TILT_DETECT -- requirements
Module: accel_tilt_detect

Interface
REQ-001 SHALL have parameter THRESH, default 12'd256, the tilt magnitude threshold in LSB (1 mg/LSB).
REQ-002 SHALL have parameter STABLE_CNT, default 3, the number of consecutive equal candidate codes required to commit a tilt.
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all flops on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port round_done, input, 1 bit: rising edge means x_raw/y_raw/z_raw hold a complete new triple; asynchronous to CLK (SPI domain).
REQ-006 SHALL have ports x_raw, y_raw, z_raw, each input, 12 bits: two's-complement acceleration, stable while round_done is high.
REQ-007 SHALL have ports x_avg, y_avg, z_avg, each output, 12 bits: two's-complement 4-sample moving average.
REQ-008 SHALL have port avg_valid, output, 1 bit: one-cycle pulse when new averages are presented.
REQ-009 SHALL have port tilt, output, 3 bits: committed orientation, 0 FLAT, 1 LEFT, 2 RIGHT, 3 FORWARD, 4 BACK, 5 INVERTED.
REQ-010 SHALL have port tilt_change, output, 1 bit: one-cycle pulse when tilt takes a new value.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when a sample edge is lost.

Function
REQ-012 SHALL synchronise round_done through two flops, plus a third flop for edge detection; edge = sync2 & ~sync3.
REQ-013 SHALL run FSM IDLE -> SHIFT -> SUM -> CLASS -> DECIDE -> IDLE, one cycle per state except IDLE.
REQ-014 IDLE: on edge or pending flag, SHALL capture x_raw/y_raw/z_raw into staging registers, clear pending, and go to SHIFT.
REQ-015 SHIFT: SHALL push the staged sample into a 4-entry history per axis (oldest discarded) and increment the saturating fill count (max 4).
REQ-016 SUM: SHALL form 14-bit sign-extended sums of the 4 entries per axis; no overflow is possible.
REQ-017 CLASS: SHALL register avg = sum >>> 2 (arithmetic, floor toward minus infinity), truncated to 12 bits, on x_avg/y_avg/z_avg.
REQ-018 CLASS: SHALL pulse avg_valid only when fill count = 4; with fill < 4, avg outputs update but avg_valid stays 0 and DECIDE SHALL leave tilt logic untouched.
REQ-019 Latency: counting the first CLK edge that samples round_done=1 as edge 1, avg_valid SHALL be high in the cycle after edge 6, and tilt/tilt_change SHALL update at edge 7.
REQ-020 Candidate code, evaluated on 13-bit absolute values (|-2048| = 2048), in priority order:
  - |x| > THRESH and |x| >= |y|: x < 0 -> LEFT, else RIGHT.
  - else if |y| > THRESH: y > 0 -> FORWARD, else BACK.
  - else if z < -THRESH -> INVERTED.
  - else FLAT.
  - A value equal to THRESH does not qualify.
REQ-021 DECIDE: if the candidate equals the previous candidate, SHALL increment the run counter (saturating at STABLE_CNT); otherwise the run counter SHALL be set to 1.
REQ-022 When the run counter reaches STABLE_CNT and candidate differs from tilt, SHALL load tilt and pulse tilt_change for one cycle.
REQ-023 An edge arriving while the FSM is not in IDLE SHALL set pending; an edge arriving while pending is already set SHALL set overrun.
REQ-024 An edge coinciding with the IDLE-exit cycle SHALL be serviced directly, not counted as pending.

Reset
REQ-025 reset low SHALL asynchronously clear the synchronisers, history, sums, fill count, run counter, previous candidate (FLAT), pending, overrun, all outputs (averages 0, tilt 0, pulses 0), and put the FSM in IDLE.
REQ-026 Reset asserted mid-pipeline SHALL discard the in-flight sample; the first post-reset edge SHALL be treated as sample 1 of 4.

Verification
REQ-027 Reset: assert reset mid-SUM -> all outputs 0, FSM IDLE, no avg_valid pulse for the next 3 rounds.
REQ-028 Fill/threshold: 6 rounds with x=+300, y=z=0 -> avg_valid on rounds 4-6 only, x_avg=300; tilt 0->2 with tilt_change at round 6 (STABLE_CNT=3).
REQ-029 Rounding: x sequence 1,2,2,2 -> x_avg=1; sequence -1,-2,-2,-2 -> x_avg=-2 (0xFFE).
REQ-030 Extremes: four rounds x=-2048 (0x800), y=+2047 -> x_avg=0x800, candidate LEFT because |x| = 2048 > 2047.
REQ-031 Boundary: x=y=256, z=0 -> FLAT; z=-257, x=y=0 -> INVERTED after 3 qualifying rounds.
REQ-032 Overrun: three round_done edges within 4 CLK -> one sample serviced directly, one pending, overrun=1 stays set until reset.

Source files
------------

// File: rtl/accel_tilt_detect.sv
// Accelerometer tilt detector: synchronises the SPI round_done strobe, keeps a
// 4-sample moving average per axis and commits a debounced orientation code.
module accel_tilt_detect #(
  parameter logic [11:0] THRESH     = 12'd256,
  parameter int          STABLE_CNT = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        round_done,
  input  logic [11:0] x_raw,
  input  logic [11:0] y_raw,
  input  logic [11:0] z_raw,
  output logic [11:0] x_avg,
  output logic [11:0] y_avg,
  output logic [11:0] z_avg,
  output logic        avg_valid,
  output logic [2:0]  tilt,
  output logic        tilt_change,
  output logic        overrun
);

  localparam int RW = $clog2(STABLE_CNT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CNT);
  localparam logic [12:0] THRESH_ABS = {1'b0, THRESH};
  localparam logic signed [12:0] NEG_THRESH = -$signed({1'b0, THRESH});

  localparam logic [2:0] FLAT     = 3'd0;
  localparam logic [2:0] LEFT     = 3'd1;
  localparam logic [2:0] RIGHT    = 3'd2;
  localparam logic [2:0] FORWARD  = 3'd3;
  localparam logic [2:0] BACK     = 3'd4;
  localparam logic [2:0] INVERTED = 3'd5;

  typedef enum logic [2:0] {IDLE, SHIFT, SUM, CLASS, DECIDE} state_t;

  state_t state, next_state;

  logic sync1, sync2, sync3;
  logic sample_edge;
  logic pending;
  logic [11:0] x_stage, y_stage, z_stage;
  logic [11:0] x_hist [4];
  logic [11:0] y_hist [4];
  logic [11:0] z_hist [4];
  logic [2:0]  fill_cnt;
  logic [13:0] x_sum, y_sum, z_sum;
  logic [RW-1:0] run_cnt, run_next;
  logic [2:0]  prev_cand, cand;
  logic [12:0] x_abs, y_abs;
  logic unused_sum_lsbs;

  function automatic logic [13:0] sum4(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c, input logic [11:0] d);
    return {{2{a[11]}}, a} + {{2{b[11]}}, b} + {{2{c[11]}}, c} + {{2{d[11]}}, d};
  endfunction

  // 13-bit result so that -2048 maps to +2048 without wrapping
  function automatic logic [12:0] abs13(input logic [11:0] v);
    logic [12:0] ext;
    ext = {v[11], v};
    return v[11] ? (13'd0 - ext) : ext;
  endfunction

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= round_done;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign sample_edge = sync2 & ~sync3;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_edge || pending) next_state = SHIFT;
      SHIFT:   next_state = SUM;
      SUM:     next_state = CLASS;
      CLASS:   next_state = DECIDE;
      DECIDE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Averaging datapath plus the lost-sample bookkeeping
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      x_stage   <= '0;
      y_stage   <= '0;
      z_stage   <= '0;
      for (int i = 0; i < 4; i++) begin
        x_hist[i] <= '0;
        y_hist[i] <= '0;
        z_hist[i] <= '0;
      end
      fill_cnt  <= '0;
      x_sum     <= '0;
      y_sum     <= '0;
      z_sum     <= '0;
      x_avg     <= '0;
      y_avg     <= '0;
      z_avg     <= '0;
      avg_valid <= 1'b0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (state == IDLE) begin
        if (sample_edge || pending) begin
          x_stage <= x_raw;
          y_stage <= y_raw;
          z_stage <= z_raw;
          pending <= 1'b0;
        end
      end else if (sample_edge) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
      case (state)
        SHIFT: begin
          x_hist[0] <= x_stage;
          y_hist[0] <= y_stage;
          z_hist[0] <= z_stage;
          for (int i = 1; i < 4; i++) begin
            x_hist[i] <= x_hist[i-1];
            y_hist[i] <= y_hist[i-1];
            z_hist[i] <= z_hist[i-1];
          end
          if (fill_cnt != 3'd4) fill_cnt <= fill_cnt + 3'd1;
        end
        SUM: begin
          x_sum <= sum4(x_hist[0], x_hist[1], x_hist[2], x_hist[3]);
          y_sum <= sum4(y_hist[0], y_hist[1], y_hist[2], y_hist[3]);
          z_sum <= sum4(z_hist[0], z_hist[1], z_hist[2], z_hist[3]);
        end
        CLASS: begin
          x_avg     <= x_sum[13:2];
          y_avg     <= y_sum[13:2];
          z_avg     <= z_sum[13:2];
          avg_valid <= (fill_cnt == 3'd4);
        end
        default: ;
      endcase
    end
  end

  assign unused_sum_lsbs = ^{x_sum[1:0], y_sum[1:0], z_sum[1:0]};

  always_comb begin
    x_abs = abs13(x_avg);
    y_abs = abs13(y_avg);
    cand  = FLAT;
    if (x_abs > THRESH_ABS && x_abs >= y_abs)
      cand = x_avg[11] ? LEFT : RIGHT;
    else if (y_abs > THRESH_ABS)
      cand = y_avg[11] ? BACK : FORWARD;
    else if ($signed({z_avg[11], z_avg}) < NEG_THRESH)
      cand = INVERTED;
  end

  always_comb begin
    run_next = RW'(1);
    if (cand == prev_cand)
      run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + 1'b1;
  end

  // Debounce: a new orientation commits only after STABLE_CNT matching full averages
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      prev_cand   <= FLAT;
      run_cnt     <= '0;
      tilt        <= FLAT;
      tilt_change <= 1'b0;
    end else begin
      tilt_change <= 1'b0;
      if (state == DECIDE && fill_cnt == 3'd4) begin
        prev_cand <= cand;
        run_cnt   <= run_next;
        if (run_next == RUN_MAX && cand != tilt) begin
          tilt        <= cand;
          tilt_change <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_tilt_detect.sv
// Directed self-checking bench for accel_tilt_detect: averaging, latency,
// debounced tilt commits, threshold boundaries, reset and overrun handling.
module tb_accel_tilt_detect;

  logic        CLK;
  logic        reset;
  logic        round_done;
  logic [11:0] x_raw, y_raw, z_raw;
  logic [11:0] x_avg, y_avg, z_avg;
  logic        avg_valid;
  logic [2:0]  tilt;
  logic        tilt_change;
  logic        overrun;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt, change_cnt, valid_cycle, change_cycle;
  int total_change;

  accel_tilt_detect dut (
    .CLK(CLK),
    .reset(reset),
    .round_done(round_done),
    .x_raw(x_raw),
    .y_raw(y_raw),
    .z_raw(z_raw),
    .x_avg(x_avg),
    .y_avg(y_avg),
    .z_avg(z_avg),
    .avg_valid(avg_valid),
    .tilt(tilt),
    .tilt_change(tilt_change),
    .overrun(overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sample round; k counts CLK edges since round_done rose (edge 1 samples it)
  task automatic apply_stimulus(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    @(negedge CLK);
    x_raw = x;
    y_raw = y;
    z_raw = z;
    round_done = 1'b1;
    valid_cnt = 0;
    change_cnt = 0;
    valid_cycle = 0;
    change_cycle = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      if (avg_valid) begin
        valid_cnt++;
        valid_cycle = k;
      end
      if (tilt_change) begin
        change_cnt++;
        change_cycle = k;
      end
      if (k == 4) round_done = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    round_done = 1'b0;
    x_raw = '0;
    y_raw = '0;
    z_raw = '0;
    repeat (3) @(negedge CLK);
    check_output("rst_tilt", 32'(tilt), 32'd0);
    check_output("rst_x_avg", 32'(x_avg), 32'd0);
    check_output("rst_avg_valid", 32'(avg_valid), 32'd0);
    check_output("rst_tilt_change", 32'(tilt_change), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;

    // Fill and threshold: x=+300 commits RIGHT on the sixth round
    for (int r = 1; r <= 6; r++) begin
      apply_stimulus(12'd300, 12'd0, 12'd0);
      check_output($sformatf("fill_valid_cnt_r%0d", r), 32'(valid_cnt), (r >= 4) ? 32'd1 : 32'd0);
      check_output($sformatf("fill_change_cnt_r%0d", r), 32'(change_cnt), (r == 6) ? 32'd1 : 32'd0);
      check_output($sformatf("fill_tilt_r%0d", r), 32'(tilt), (r == 6) ? 32'd2 : 32'd0);
      if (r >= 4) begin
        check_output($sformatf("fill_valid_cycle_r%0d", r), 32'(valid_cycle), 32'd6);
        check_output($sformatf("fill_x_avg_r%0d", r), 32'(x_avg), 32'd300);
      end
    end
    check_output("fill_change_cycle", 32'(change_cycle), 32'd7);

    $display("[TB] reset asserted while the pipeline is in SUM");
    @(negedge CLK);
    x_raw = 12'd300;
    round_done = 1'b1;
    repeat (4) @(negedge CLK);
    reset = 1'b0;
    round_done = 1'b0;
    @(negedge CLK);
    check_output("midrst_tilt", 32'(tilt), 32'd0);
    check_output("midrst_x_avg", 32'(x_avg), 32'd0);
    check_output("midrst_avg_valid", 32'(avg_valid), 32'd0);
    check_output("midrst_tilt_change", 32'(tilt_change), 32'd0);
    reset = 1'b1;

    // Three post-reset rounds must not validate; they also seed the rounding case 1,2,2,2
    apply_stimulus(12'd1, 12'd0, 12'd0);
    check_output("postrst_valid_r1", 32'(valid_cnt), 32'd0);
    apply_stimulus(12'd2, 12'd0, 12'd0);
    check_output("postrst_valid_r2", 32'(valid_cnt), 32'd0);
    apply_stimulus(12'd2, 12'd0, 12'd0);
    check_output("postrst_valid_r3", 32'(valid_cnt), 32'd0);
    apply_stimulus(12'd2, 12'd0, 12'd0);
    check_output("round_pos_valid", 32'(valid_cnt), 32'd1);
    check_output("round_pos_x_avg", 32'(x_avg), 32'd1);

    do_reset();
    apply_stimulus(12'hFFF, 12'd0, 12'd0);
    apply_stimulus(12'hFFE, 12'd0, 12'd0);
    apply_stimulus(12'hFFE, 12'd0, 12'd0);
    apply_stimulus(12'hFFE, 12'd0, 12'd0);
    check_output("round_neg_x_avg", 32'(x_avg), 32'hFFE);

    // Extremes: |-2048| beats +2047, so LEFT
    do_reset();
    for (int r = 1; r <= 6; r++) begin
      apply_stimulus(12'h800, 12'h7FF, 12'd0);
      if (r == 4) begin
        check_output("ext_x_avg", 32'(x_avg), 32'h800);
        check_output("ext_y_avg", 32'(y_avg), 32'h7FF);
      end
    end
    check_output("ext_tilt", 32'(tilt), 32'd1);
    check_output("ext_change_cnt", 32'(change_cnt), 32'd1);

    // Boundary: values equal to THRESH stay FLAT
    do_reset();
    total_change = 0;
    for (int r = 1; r <= 6; r++) begin
      apply_stimulus(12'd256, 12'd256, 12'd0);
      total_change += change_cnt;
    end
    check_output("bnd_flat_tilt", 32'(tilt), 32'd0);
    check_output("bnd_flat_changes", 32'(total_change), 32'd0);
    check_output("bnd_flat_x_avg", 32'(x_avg), 32'd256);

    // z=-257 averages in over four rounds, then needs three matching decisions
    for (int r = 1; r <= 6; r++) begin
      apply_stimulus(12'd0, 12'd0, 12'hEFF);
      if (r == 5) check_output("bnd_inv_tilt_r5", 32'(tilt), 32'd0);
    end
    check_output("bnd_inv_tilt_r6", 32'(tilt), 32'd5);
    check_output("bnd_inv_change", 32'(change_cnt), 32'd1);
    check_output("bnd_inv_z_avg", 32'(z_avg), 32'hEFF);

    // Overrun: three round_done rises within four cycles
    do_reset();
    @(negedge CLK);
    x_raw = 12'd400;
    y_raw = 12'd0;
    z_raw = 12'd0;
    round_done = 1'b1;
    @(negedge CLK);
    round_done = 1'b0;
    @(negedge CLK);
    round_done = 1'b1;
    @(negedge CLK);
    round_done = 1'b0;
    @(negedge CLK);
    round_done = 1'b1;
    @(negedge CLK);
    round_done = 1'b0;
    repeat (14) @(negedge CLK);
    check_output("ovr_flag", 32'(overrun), 32'd1);
    check_output("ovr_pending_serviced_x_avg", 32'(x_avg), 32'd200);
    apply_stimulus(12'd400, 12'd0, 12'd0);
    check_output("ovr_valid_fill3", 32'(valid_cnt), 32'd0);
    apply_stimulus(12'd400, 12'd0, 12'd0);
    check_output("ovr_valid_fill4", 32'(valid_cnt), 32'd1);
    check_output("ovr_x_avg_full", 32'(x_avg), 32'd400);
    check_output("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    @(negedge CLK);
    check_output("ovr_cleared", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
